// File: rtl/prn_seq_ctrl.sv
// ============================================================================
//  Module   : prn_seq_ctrl
//  Purpose  : Sequencing controller for the 10-bit PRN sequence generator.
//             Accepts seed/length jobs, loads the seed by holding the
//             generator in reset for one cycle, runs it for a fixed number of
//             chips (or continuously), re-times the chip stream, flags
//             full-period epochs and rejects the all-zero lock-up seed.
//  Options  : PRN_LOCKUP_CHK_EN - enables lock-up (zero state) and
//             period-length checking while running.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module prn_seq_ctrl #(
    parameter int LEN_W  = 16,
    parameter int SEED_W = 10,
    parameter int PERIOD = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [SEED_W-1:0] cfg_seed,
    input  logic [LEN_W-1:0]  cfg_len,
    input  logic              stop,
    output logic              gen_rst,
    output logic [SEED_W-1:0] gen_seed,
    input  logic [SEED_W-1:0] gen_state,
    input  logic              gen_stream,
    output logic              chip_out,
    output logic              chip_valid,
    output logic              epoch,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    localparam logic [SEED_W-1:0] C_SEED_RST = SEED_W'(1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [SEED_W-1:0] r_seed_q;
    logic [LEN_W-1:0]  r_len_q;
    logic [LEN_W-1:0]  r_cnt;
    logic              r_was_run;
    logic              r_chip_out;
    logic              r_chip_valid;
    logic              r_epoch;
    logic              r_done;
    logic              r_err;

    logic w_run;
    logic w_accept;
    logic w_zero_seed;
    logic w_first;
    logic w_match;
    logic w_last;
    logic w_abort;

    assign w_run       = (r_state == S_RUN);
    assign w_accept    = cfg_valid && (r_state == S_IDLE);
    assign w_zero_seed = (cfg_seed == '0);
    // The generator holds the loaded seed during the first RUN cycle, so a
    // seed match there is not a completed period.
    assign w_first     = w_run && !r_was_run;
    assign w_match     = w_run && !w_first && (gen_state == r_seed_q);
    assign w_last      = (r_len_q != '0) && (r_cnt == (r_len_q - LEN_W'(1)));

`ifdef PRN_LOCKUP_CHK_EN
    localparam int              PW       = $clog2(PERIOD + 1);
    localparam logic [PW-1:0]   C_PERIOD = PW'(PERIOD);

    logic [PW-1:0] r_per;
    logic [PW-1:0] w_dist;
    logic          w_per_bad;

    // Distance in RUN cycles from the previous epoch (or from RUN entry).
    assign w_dist    = w_first ? '0 : r_per;
    assign w_per_bad = (r_len_q == '0) &&
                       (w_match ? (w_dist != C_PERIOD) : (w_dist == C_PERIOD));
    assign w_abort   = w_run && ((gen_state == '0) || w_per_bad);

    // Period distance counter, restarted on each epoch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_per <= '0;
        end else if (w_run) begin
            r_per <= w_match ? PW'(1) : (w_dist + PW'(1));
        end
    end
`else
    logic [31:0] w_unused_period;
    assign w_unused_period = PERIOD;
    assign w_abort         = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept && !w_zero_seed) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_RUN;
            S_RUN:   if (w_abort || w_last || stop) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State-decoded outputs: generator held in reset/load outside RUN.
    always_comb begin
        cfg_ready = 1'b0;
        gen_rst   = 1'b1;
        busy      = 1'b0;
        case (r_state)
            S_IDLE:  cfg_ready = 1'b1;
            S_LOAD:  busy      = 1'b1;
            S_RUN: begin
                gen_rst = 1'b0;
                busy    = 1'b1;
            end
            default: cfg_ready = 1'b0;
        endcase
    end

    assign gen_seed   = r_seed_q;
    assign chip_out   = r_chip_out;
    assign chip_valid = r_chip_valid;
    assign epoch      = r_epoch;
    assign done       = r_done;
    assign err        = r_err;

    // Job registers, chip re-timing and status pulses.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_seed_q     <= C_SEED_RST;
            r_len_q      <= '0;
            r_cnt        <= '0;
            r_was_run    <= 1'b0;
            r_chip_out   <= 1'b0;
            r_chip_valid <= 1'b0;
            r_epoch      <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_was_run    <= w_run;
            r_chip_valid <= w_run && !w_abort;
            r_epoch      <= w_match && !w_abort;
            r_done       <= (w_accept && w_zero_seed) ||
                            (w_run && (w_abort || w_last || stop));
            if (w_run && !w_abort) begin
                r_chip_out <= gen_stream;
            end
            if (w_accept) begin
                r_seed_q <= cfg_seed;
                r_len_q  <= cfg_len;
                r_cnt    <= '0;
                r_err    <= w_zero_seed;
            end else if (w_run) begin
                r_cnt <= r_cnt + LEN_W'(1);
                if (w_abort) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_prn_seq_ctrl.sv
// ============================================================================
//  Module   : tb_prn_seq_ctrl
//  Purpose  : Scoreboard testbench for prn_seq_ctrl with a 10-bit maximal
//             LFSR generator model (x^10 + x^7 + 1).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prn_seq_ctrl;

    typedef struct packed {
        logic chip;
        logic epoch;
        logic last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [9:0]  cfg_seed;
    logic [15:0] cfg_len;
    logic        stop;
    logic        gen_rst;
    logic [9:0]  gen_seed;
    logic [9:0]  gen_state;
    logic        gen_stream;
    logic        chip_out;
    logic        chip_valid;
    logic        epoch;
    logic        busy;
    logic        done;
    logic        err;

    logic [9:0]  r_gen;
    logic        force_zero;
    logic        mon_en;
    int          n_chk;
    int          n_err;
    int          n_epoch;
    exp_t        q_chip[$];
    logic        q_done[$];

    always #5 clk = ~clk;

    prn_seq_ctrl #(.LEN_W(16), .SEED_W(10), .PERIOD(1023)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_seed   (cfg_seed),
        .cfg_len    (cfg_len),
        .stop       (stop),
        .gen_rst    (gen_rst),
        .gen_seed   (gen_seed),
        .gen_state  (gen_state),
        .gen_stream (gen_stream),
        .chip_out   (chip_out),
        .chip_valid (chip_valid),
        .epoch      (epoch),
        .busy       (busy),
        .done       (done),
        .err        (err)
    );

    function automatic logic [9:0] lfsr_step(input logic [9:0] s);
        return {s[8:0], s[9] ^ s[6]};
    endfunction

    // Generator model: loads the seed while held in reset.
    always @(posedge clk) begin
        if (gen_rst) r_gen <= gen_seed;
        else         r_gen <= lfsr_step(r_gen);
    end
    assign gen_state  = force_zero ? 10'd0 : r_gen;
    assign gen_stream = r_gen[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a chip or done.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("epoch_gated", {31'd0, epoch & ~chip_valid}, 32'd0);
            if (chip_valid) begin
                if (epoch) n_epoch++;
                if (q_chip.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL chip_spurious: chip_valid=1 chip_out=%0b, none expected", chip_out);
                end else begin
                    exp_t e;
                    e = q_chip.pop_front();
                    chk("chip_out",   {31'd0, chip_out}, {31'd0, e.chip});
                    chk("chip_epoch", {31'd0, epoch},    {31'd0, e.epoch});
                    chk("chip_done",  {31'd0, done},     {31'd0, e.last});
                end
            end
            if (done) begin
                if (q_done.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL done_spurious: done=1 err=%0b, none expected", err);
                end else begin
                    logic e_err;
                    e_err = q_done.pop_front();
                    chk("done_err", {31'd0, err}, {31'd0, e_err});
                end
            end
        end
    end

    // Expected chips of a job from a software generator model.
    task automatic push_job(input logic [9:0] seed, input int n, input bit done_last);
        logic [9:0] s;
        s = seed;
        for (int k = 0; k < n; k++) begin
            exp_t e;
            e.chip  = s[9];
            e.epoch = (k != 0) && (s == seed);
            e.last  = done_last && (k == n - 1);
            q_chip.push_back(e);
            s = lfsr_step(s);
        end
    endtask

    // Accept cycle; returns #1 after the accepting edge.
    task automatic start_job(input logic [9:0] seed, input logic [15:0] len);
        chk("cfg_ready_idle", {31'd0, cfg_ready}, 32'd1);
        cfg_valid = 1'b1;
        cfg_seed  = seed;
        cfg_len   = len;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
    endtask

    task automatic check_load(input logic [9:0] seed);
        chk("load_gen_rst",   {31'd0, gen_rst},   32'd1);
        chk("load_gen_seed",  {22'd0, gen_seed},  {22'd0, seed});
        chk("load_busy",      {31'd0, busy},      32'd1);
        chk("load_cfg_ready", {31'd0, cfg_ready}, 32'd0);
    endtask

    task automatic drain(input string name, input int max_cyc);
        int i;
        i = 0;
        while ((q_chip.size() != 0 || q_done.size() != 0) && i < max_cyc) begin
            @(posedge clk); #1;
            i++;
        end
        chk(name, q_chip.size() + q_done.size(), 32'd0);
    endtask

    initial begin
        logic [7:0] hand;
        n_chk = 0; n_err = 0; n_epoch = 0;
        mon_en = 1'b0; force_zero = 1'b0;
        rst = 1'b0; cfg_valid = 1'b0; cfg_seed = '0; cfg_len = '0; stop = 1'b0;

        // Reset values.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cfg_ready",  {31'd0, cfg_ready},  32'd1);
        chk("rst_gen_rst",    {31'd0, gen_rst},    32'd1);
        chk("rst_gen_seed",   {22'd0, gen_seed},   32'h001);
        chk("rst_chip_out",   {31'd0, chip_out},   32'd0);
        chk("rst_chip_valid", {31'd0, chip_valid}, 32'd0);
        chk("rst_epoch",      {31'd0, epoch},      32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_done",       {31'd0, done},       32'd0);
        chk("rst_err",        {31'd0, err},        32'd0);
        rst = 1'b1;
        mon_en = 1'b1;
        @(posedge clk); #1;

        // Finite job, 8 chips; hand-derived chips are seed bits 9..2.
        hand = 8'b1010_1110;
        for (int k = 0; k < 8; k++) begin
            exp_t e;
            e.chip  = hand[7-k];
            e.epoch = 1'b0;
            e.last  = (k == 7);
            q_chip.push_back(e);
        end
        q_done.push_back(1'b0);
        start_job(10'b1010111000, 16'd8);
        check_load(10'h2B8);
        drain("fin8_drain", 50);
        chk("fin8_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("fin8_err",       {31'd0, err},       32'd0);
        chk("fin8_busy",      {31'd0, busy},      32'd0);

        // Continuous job stopped during chip 2050.
        n_epoch = 0;
        push_job(10'h2B8, 2051, 1'b1);
        q_done.push_back(1'b0);
        start_job(10'h2B8, 16'd0);
        check_load(10'h2B8);
        repeat (2051) @(posedge clk);
        #1 stop = 1'b1;
        @(posedge clk); #1 stop = 1'b0;
        drain("cont_drain", 20);
        chk("cont_epochs", n_epoch, 32'd2);
        chk("cont_idle", {31'd0, cfg_ready}, 32'd1);

        // Zero seed: rejected without LOAD.
        q_done.push_back(1'b1);
        start_job(10'h000, 16'd5);
        chk("zero_done",    {31'd0, done},    32'd1);
        chk("zero_err",     {31'd0, err},     32'd1);
        chk("zero_gen_rst", {31'd0, gen_rst}, 32'd1);
        chk("zero_busy",    {31'd0, busy},    32'd0);
        @(posedge clk); #1;
        chk("zero_done_pulse", {31'd0, done},    32'd0);
        chk("zero_err_hold",   {31'd0, err},     32'd1);
        chk("zero_gen_rst2",   {31'd0, gen_rst}, 32'd1);
        drain("zero_drain", 5);

        // Reset during chip 40 of a 100-chip job: 40 chips, no done.
        push_job(10'h3C5, 40, 1'b0);
        start_job(10'h3C5, 16'd100);
        check_load(10'h3C5);
        repeat (41) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_busy",       {31'd0, busy},       32'd0);
        chk("mid_rst_chip_valid", {31'd0, chip_valid}, 32'd0);
        chk("mid_rst_done",       {31'd0, done},       32'd0);
        chk("mid_rst_cfg_ready",  {31'd0, cfg_ready},  32'd1);
        chk("mid_rst_err_clear",  {31'd0, err},        32'd0);
        drain("mid_rst_drain", 2);
        rst = 1'b1;
        push_job(10'h0F0, 5, 1'b1);
        q_done.push_back(1'b0);
        start_job(10'h0F0, 16'd5);
        check_load(10'h0F0);
        drain("post_rst_drain", 30);

        // Generator state forced to zero during chip 5 of a 20-chip job.
`ifdef PRN_LOCKUP_CHK_EN
        push_job(10'h155, 5, 1'b0);
        q_done.push_back(1'b1);
`else
        push_job(10'h155, 20, 1'b1);
        q_done.push_back(1'b0);
`endif
        start_job(10'h155, 16'd20);
        check_load(10'h155);
        repeat (6) @(posedge clk);
        #1 force_zero = 1'b1;
        @(posedge clk); #1 force_zero = 1'b0;
`ifdef PRN_LOCKUP_CHK_EN
        chk("lock_chip_valid", {31'd0, chip_valid}, 32'd0);
        chk("lock_done",       {31'd0, done},       32'd1);
        chk("lock_err",        {31'd0, err},        32'd1);
`else
        chk("nolock_chip_valid", {31'd0, chip_valid}, 32'd1);
        chk("nolock_busy",       {31'd0, busy},       32'd1);
`endif
        drain("lock_drain", 40);
        chk("lock_idle", {31'd0, cfg_ready}, 32'd1);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
